// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg
// Shared types and lane constants for the memory-access stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) || ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align
// Store byte-lane steering and load lane extraction with sign/zero extension.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = rdata[{addr_lo, 3'b000} +: 8];
        // Half lane uses only a[1]; a[0] is either trapped upstream or ignored.
        w_half    = rdata[{addr_lo[1], 4'b0000} +: 16];
        be        = BE_WORD;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SIZE_BYTE: begin
                be        = BE_BYTE << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                be        = BE_HALF << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{~is_unsigned & w_half[15]}}, w_half};
            end
            default: begin
                be        = BE_WORD;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage
// Pipeline memory stage: req/gnt/rvalid bus FSM, lane alignment, MEM/WB reg.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int WB_SEL_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_ex,
    input  logic [XLEN-1:0]         alu_ex,
    input  logic [XLEN-1:0]         rs2_ex,
    input  logic [1:0]              mem_op_ex,
    input  logic [1:0]              mem_size_ex,
    input  logic                    mem_unsigned_ex,
    input  logic [WB_SEL_WIDTH-1:0] wb_sel_ex,
    input  logic [4:0]              rd_ex,
    input  logic                    reg_we_ex,
    output logic                    stall_mem,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [XLEN-1:0]         dmem_addr,
    output logic [3:0]              dmem_be,
    output logic [XLEN-1:0]         dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [XLEN-1:0]         dmem_rdata,
    output logic [XLEN-1:0]         alu_wb,
    output logic [XLEN-1:0]         mem_wb,
    output logic [WB_SEL_WIDTH-1:0] wb_sel,
    output logic [4:0]              rd_wb,
    output logic                    reg_we_wb,
    output logic                    valid_wb,
    output logic                    misalign_wb
);

    mem_state_t r_state;
    mem_op_t    w_op;
    mem_size_t  w_size;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_mem;
    logic       w_misalign;
    logic       w_bus;
    logic       w_req;
    logic       w_retire;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_data;

    assign w_op       = mem_op_t'(mem_op_ex);
    assign w_size     = mem_size_t'(mem_size_ex);
    assign w_is_load  = (w_op == MEM_LOAD);
    assign w_is_store = (w_op == MEM_STORE);
    assign w_mem      = valid_ex && (w_is_load || w_is_store);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = w_mem && is_misaligned(w_size, alu_ex[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_bus = w_mem && !w_misalign;
    // In REQ the EX/MEM inputs are frozen by the stall, so the request simply holds.
    assign w_req = (r_state == ST_REQ) || ((r_state == ST_IDLE) && w_bus);

    always_comb begin
        w_retire = 1'b0;
        if (valid_ex) begin
            if (!w_bus) begin
                w_retire = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE, ST_REQ: w_retire = dmem_gnt && w_is_store;
                    ST_WAIT:         w_retire = dmem_rvalid;
                    default:         w_retire = 1'b0;
                endcase
            end
        end
    end

    assign stall_mem  = w_mem && !w_retire;
    assign dmem_req   = w_req;
    assign dmem_we    = w_req && w_is_store;
    assign dmem_addr  = w_req ? {alu_ex[XLEN-1:2], 2'b00} : '0;
    assign dmem_be    = w_req ? w_be : 4'b0000;
    assign dmem_wdata = w_req ? w_wdata : '0;

    lsu_align u_lsu_align (
        .addr_lo     (alu_ex[1:0]),
        .size        (w_size),
        .is_unsigned (mem_unsigned_ex),
        .store_data  (rs2_ex),
        .rdata       (dmem_rdata),
        .be          (w_be),
        .wdata       (w_wdata),
        .load_data   (w_load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            alu_wb      <= '0;
            mem_wb      <= '0;
            wb_sel      <= '0;
            rd_wb       <= '0;
            reg_we_wb   <= 1'b0;
            valid_wb    <= 1'b0;
            misalign_wb <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_bus) begin
                        if (dmem_gnt) r_state <= w_is_load ? ST_WAIT : ST_IDLE;
                        else          r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) r_state <= w_is_load ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (dmem_rvalid) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_retire) begin
                valid_wb    <= 1'b1;
                alu_wb      <= alu_ex;
                mem_wb      <= (w_is_load && !w_misalign) ? w_load_data : '0;
                wb_sel      <= wb_sel_ex;
                rd_wb       <= rd_ex;
                reg_we_wb   <= reg_we_ex && !w_misalign;
                misalign_wb <= w_misalign;
            end else begin
                valid_wb    <= 1'b0;
                reg_we_wb   <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage
// Randomized self-checking bench for mem_stage against a byte-lane model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam int WBW = 2;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, valid_ex, mem_unsigned_ex, reg_we_ex;
    logic [31:0]     alu_ex, rs2_ex, dmem_rdata;
    logic [1:0]      mem_op_ex, mem_size_ex;
    logic [WBW-1:0]  wb_sel_ex, wb_sel;
    logic [4:0]      rd_ex, rd_wb;
    logic            stall_mem, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0]     dmem_addr, dmem_wdata, alu_wb, mem_wb;
    logic [3:0]      dmem_be;
    logic            reg_we_wb, valid_wb, misalign_wb;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.XLEN(32), .WB_SEL_WIDTH(WBW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_ex(valid_ex), .alu_ex(alu_ex), .rs2_ex(rs2_ex),
        .mem_op_ex(mem_op_ex), .mem_size_ex(mem_size_ex), .mem_unsigned_ex(mem_unsigned_ex),
        .wb_sel_ex(wb_sel_ex), .rd_ex(rd_ex), .reg_we_ex(reg_we_ex), .stall_mem(stall_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .alu_wb(alu_wb), .mem_wb(mem_wb), .wb_sel(wb_sel),
        .rd_wb(rd_wb), .reg_we_wb(reg_we_wb), .valid_wb(valid_wb), .misalign_wb(misalign_wb)
    );

    // Reference model: accesses are viewed as runs of n bytes inside a 4-byte word.
    function automatic int nbytes_of(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic int start_of(input logic [1:0] size, input logic [31:0] addr);
        int lo = int'(addr % 4);
        return lo - (lo % nbytes_of(size));
    endfunction

    function automatic bit model_mis(input logic [1:0] op, input logic [1:0] size, input logic [31:0] addr);
        return MIS_EN && (op == 2'd1 || op == 2'd2) && ((addr % nbytes_of(size)) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        logic [3:0] be;
        int s = start_of(size, addr);
        for (int i = 0; i < 4; i++) be[i] = (i >= s) && (i < s + nbytes_of(size));
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] rs2);
        logic [31:0] w;
        int n = nbytes_of(size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        longint v;
        longint span;
        int n = nbytes_of(size);
        span = 64'sd1 <<< (8 * n);
        v = longint'({32'd0, rdata});
        v = (v >>> (8 * start_of(size, addr))) % span;
        if (!uns && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    task automatic run_instr(input logic [1:0] op, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                             input int gdel, input int rdel, input logic [4:0] rd, input bit we,
                             input logic [WBW-1:0] ws, output logic [31:0] got_mem);
        bit is_mem  = (op == 2'd1) || (op == 2'd2);
        bit is_load = (op == 2'd1);
        bit mis     = model_mis(op, size, addr);
        bit bus     = is_mem && !mis;
        int total   = !bus ? 1 : (is_load ? gdel + rdel + 2 : gdel + 1);
        valid_ex = 1'b1; mem_op_ex = op; mem_size_ex = size; mem_unsigned_ex = uns;
        alu_ex = addr; rs2_ex = rs2; rd_ex = rd; reg_we_ex = we; wb_sel_ex = ws;
        for (int c = 0; c < total; c++) begin
            bit inreq;
            bit last;
            inreq = bus && (c <= gdel);
            last  = (c == total - 1);
            dmem_gnt    = inreq && (c == gdel);
            dmem_rvalid = (is_load && bus && last) ? 1'b1 : (inreq ? 1'($urandom_range(0, 1)) : 1'b0);
            dmem_rdata  = (is_load && bus && last) ? rdata : $urandom();
            @(negedge clk);
            n_checks++;
            if (dmem_req !== inreq) begin
                n_errors++; $display("FAIL req c%0d: got %b expected %b", c, dmem_req, inreq);
            end
            n_checks++;
            if (stall_mem !== (is_mem && !last)) begin
                n_errors++; $display("FAIL stall c%0d: got %b expected %b", c, stall_mem, is_mem && !last);
            end
            if (inreq) begin
                n_checks++;
                if (dmem_addr !== {addr[31:2], 2'b00} || dmem_we !== (op == 2'd2)) begin
                    n_errors++; $display("FAIL bus_addr: got %h/%b expected %h/%b", dmem_addr, dmem_we, {addr[31:2], 2'b00}, op == 2'd2);
                end
                if (op == 2'd2) begin
                    n_checks++;
                    if (dmem_be !== model_be(size, addr) || dmem_wdata !== model_wdata(size, rs2)) begin
                        n_errors++; $display("FAIL store_lanes: got %b/%h expected %b/%h", dmem_be, dmem_wdata, model_be(size, addr), model_wdata(size, rs2));
                    end
                end
            end
            @(posedge clk); #1;
            if (!last) begin
                n_checks++;
                if (valid_wb !== 1'b0 || reg_we_wb !== 1'b0) begin
                    n_errors++; $display("FAIL bubble c%0d: got valid=%b we=%b expected 0/0", c, valid_wb, reg_we_wb);
                end
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; valid_ex = 1'b0;
        n_checks++;
        if (valid_wb !== 1'b1 || alu_wb !== addr || rd_wb !== rd || wb_sel !== ws || reg_we_wb !== (we && !mis) || misalign_wb !== mis) begin
            n_errors++;
            $display("FAIL retire: got v=%b alu=%h rd=%0d ws=%0d we=%b mis=%b expected 1 %h %0d %0d %b %b",
                     valid_wb, alu_wb, rd_wb, wb_sel, reg_we_wb, misalign_wb, addr, rd, ws, we && !mis, mis);
        end
        if (is_load && !mis) begin
            n_checks++;
            if (mem_wb !== model_load(size, uns, addr, rdata)) begin
                n_errors++; $display("FAIL load_data: got %h expected %h", mem_wb, model_load(size, uns, addr, rdata));
            end
        end
        got_mem = mem_wb;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_ex = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        alu_ex = '0; rs2_ex = '0; mem_op_ex = '0; mem_size_ex = '0; mem_unsigned_ex = 1'b0;
        wb_sel_ex = '0; rd_ex = '0; reg_we_ex = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({valid_wb, reg_we_wb, misalign_wb, rd_wb, wb_sel} !== '0 || alu_wb !== '0 || mem_wb !== '0) begin
            n_errors++; $display("FAIL reset_wb: got v=%b alu=%h mem=%h expected zeros", valid_wb, alu_wb, mem_wb);
        end
        n_checks++;
        if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
            n_errors++; $display("FAIL reset_bus: got req=%b stall=%b expected 0/0", dmem_req, stall_mem);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        logic [31:0] m;
        run_instr(2'd0, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0, 5'd3, 1'b1, 2'd1, m);
        n_checks++;
        if (alu_wb !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL alu_wb: got %h expected DEADBEEF", alu_wb);
        end
    endtask

    task automatic test_store();
        logic [31:0] m;
        run_instr(2'd2, 2'd2, 1'b0, 32'h100, 32'h12345678, 32'h0, 0, 0, 5'd0, 1'b0, 2'd0, m);
        run_instr(2'd2, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 1, 0, 5'd0, 1'b0, 2'd0, m);
        run_instr(2'd2, 2'd0, 1'b0, 32'h201, 32'h000000A5, 32'h0, 0, 0, 5'd0, 1'b0, 2'd0, m);
    endtask

    task automatic test_load();
        logic [31:0] m;
        run_instr(2'd1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80000000, 2, 0, 5'd7, 1'b1, 2'd2, m);
        n_checks++;
        if (m !== 32'hFFFFFF80) begin
            n_errors++; $display("FAIL lb: got %h expected FFFFFF80", m);
        end
        run_instr(2'd1, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80000000, 2, 0, 5'd7, 1'b1, 2'd2, m);
        n_checks++;
        if (m !== 32'h00000080) begin
            n_errors++; $display("FAIL lbu: got %h expected 00000080", m);
        end
        run_instr(2'd1, 2'd1, 1'b0, 32'h302, 32'h0, 32'h9ABC1234, 0, 2, 5'd9, 1'b1, 2'd2, m);
        n_checks++;
        if (m !== 32'hFFFF9ABC) begin
            n_errors++; $display("FAIL lh: got %h expected FFFF9ABC", m);
        end
    endtask

    task automatic test_reset_midflight();
        valid_ex = 1'b1; mem_op_ex = 2'd1; mem_size_ex = 2'd2; alu_ex = 32'h200; rd_ex = 5'd4; reg_we_ex = 1'b1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (valid_wb !== 1'b0 || alu_wb !== '0 || rd_wb !== '0) begin
            n_errors++; $display("FAIL midreset_wb: got v=%b alu=%h rd=%0d expected zeros", valid_wb, alu_wb, rd_wb);
        end
        rst_n = 1'b1; valid_ex = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin
            n_errors++; $display("FAIL midreset_bus: got req=%b stall=%b expected 0/0", dmem_req, stall_mem);
        end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        n_checks++;
        if (valid_wb !== 1'b0 || mem_wb !== '0) begin
            n_errors++; $display("FAIL stray_rvalid: got v=%b mem=%h expected 0/0", valid_wb, mem_wb);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] m;
        run_instr(2'd1, 2'd2, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0, 5'd5, 1'b1, 2'd1, m);
        n_checks++;
        if (misalign_wb !== MIS_EN || reg_we_wb !== !MIS_EN) begin
            n_errors++; $display("FAIL misalign: got mis=%b we=%b expected %b/%b", misalign_wb, reg_we_wb, MIS_EN, !MIS_EN);
        end
        run_instr(2'd2, 2'd1, 1'b0, 32'h103, 32'h00001234, 32'h0, 1, 0, 5'd0, 1'b0, 2'd0, m);
    endtask

    task automatic test_back_to_back();
        logic [31:0] m;
        for (int i = 0; i < 60; i++) begin
            run_instr(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      $urandom(), $urandom(), $urandom(), $urandom_range(0, 2), $urandom_range(0, 2),
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), WBW'($urandom_range(0, 3)), m);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_reset_midflight();
        test_misalign();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RISC-V pipeline, between EX/MEM and the writeback stage. It performs load/store transactions on a req/gnt/rvalid data-memory bus, steers store bytes, aligns and sign/zero-extends load data, and holds the MEM/WB pipeline register that drives `alu_wb`, `mem_wb` and `wb_sel` into writeback. It stalls the front of the pipeline while a bus transaction is outstanding.

## Interface
- `XLEN`: 32, from `constants.vh`; datapath width, fixed at 32 for lane logic.
- `WB_SEL_WIDTH`: from `constants.vh`; width of writeback-select.
- One clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `valid_ex`  in  1  EX/MEM holds a valid instruction.
- `alu_ex`  in  XLEN  ALU result, which is also the effective address.
- `rs2_ex`  in  XLEN  store data.
- `mem_op_ex`  in  2  NONE=0, LOAD=1, STORE=2.
- `mem_size_ex`  in  2  BYTE=0, HALF=1, WORD=2.
- `mem_unsigned_ex`  in  1  zero-extend load (LBU/LHU).
- `wb_sel_ex`  in  WB_SEL_WIDTH  passed through to writeback.
- `rd_ex`  in  5  destination register.
- `reg_we_ex`  in  1  register write enable.
- `stall_mem`  out  1  hold IF/ID/EX; EX/MEM inputs must stay stable while high.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1=write.
- `dmem_addr`  out  XLEN  word-aligned address, `{alu_ex[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  XLEN  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  read data valid this cycle.
- `dmem_rdata`  in  XLEN  read data word.
- `alu_wb`, `mem_wb`  out  XLEN  registered ALU result and registered aligned load data.
- `wb_sel`  out  WB_SEL_WIDTH  registered writeback select.
- `rd_wb`  out  5; `reg_we_wb`  out  1; `valid_wb`  out  1; `misalign_wb`  out  1.

## Operation
- The FSM has three states: IDLE, REQ and WAIT.
- IDLE:
  - If `valid_ex` and `mem_op_ex`≠NONE, assert `dmem_req` combinationally.
  - On `dmem_gnt`: a STORE retires (stays IDLE); a LOAD moves to WAIT.
  - On no grant: move to REQ.
- REQ: hold `dmem_req` and all bus outputs stable until `dmem_gnt`, then follow the same branching as IDLE.
- WAIT: `dmem_req`=0; on `dmem_rvalid` the load retires and the FSM returns to IDLE.
- `dmem_rvalid` is ignored outside WAIT.
- `stall_mem` = memory op present AND not retiring this cycle.
- The MEM/WB register updates every cycle:
  - Retiring instruction: load its fields with `valid_wb`=1.
  - Stalled: load a bubble (`valid_wb`=0, `reg_we_wb`=0, other fields hold).
  - `valid_ex`=0: load a bubble.
- Non-memory instructions retire in the cycle they are presented.
- Store lanes:
  - BYTE: be=`0001<<a[1:0]`, wdata=`{4{rs2[7:0]}}`.
  - HALF: be=`0011<<{a[1],0}`, wdata=`{2{rs2[15:0]}}`.
  - WORD: be=`1111`.
- Load: select byte/half lane from `dmem_rdata` by `a[1:0]`, then extend per `mem_unsigned_ex` into `mem_wb`.

## Timing
- Reset values of all outputs are 0; FSM goes to IDLE. This applies mid-transaction: the request drops the next cycle and any later `rvalid` is ignored.
- Latency:
  - ALU op: result at `alu_wb` 1 cycle after presentation.
  - Store with immediate grant: 1 cycle.
  - Load: minimum 2 cycles (grant cycle + rvalid cycle); +1 per cycle without grant and per cycle of rvalid delay.
- `dmem_gnt` and `dmem_rvalid` in the same cycle while in IDLE/REQ: rvalid is ignored. Memory must return data no earlier than the cycle after the grant.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are HALF with a[0]=1, or WORD with a[1:0]≠0.
  - Such an access issues no bus request and retires in 1 cycle with `misalign_wb`=1 and `reg_we_wb`=0.
- Undefined:
  - No check; HALF ignores a[0] and WORD ignores a[1:0].
  - `misalign_wb` is tied to 0.

## Structure
- A package `mem_pkg` holds the `mem_op_t`, `mem_size_t` and `mem_state_t` enums and the lane constants.
- `XLEN` and `WB_SEL_WIDTH` remain in `constants.vh`.
- One combinational sub-module, `lsu_align`, does store steering (be/wdata) and load extraction/extension.

## Test plan
- ADD, `alu_ex`=0xDEADBEEF, NONE -> next cycle `alu_wb`=0xDEADBEEF, `valid_wb`=1, `stall_mem` never high.
- SW rs2=0x12345678 @0x100, gnt same cycle -> be=1111, addr=0x100, retire 1 cycle, no stall.
- LB @0x103, rdata=0x80000000, gnt after 2 cycles, rvalid 1 later -> `stall_mem` high 3 cycles, `mem_wb`=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH rs2=0xABCD @0x102 -> be=1100, wdata=0xABCDABCD.
- LW pending in WAIT, `rst_n`=0 one cycle, stray rvalid after -> outputs 0, no retire.
- LW @0x101 with `MEM_MISALIGN_TRAP_EN` -> no `dmem_req`, `misalign_wb`=1, `reg_we_wb`=0.
